// File: rtl/screen_line_prefetch_if.sv
// screen_line_prefetch_if: screen RAM read bus between the line prefetcher and screen RAM
interface screen_line_prefetch_if #(parameter int ADDR_WIDTH = 11);
  logic                  screen_read_en;
  logic [ADDR_WIDTH-1:0] screen_read_addr;
  logic [7:0]            screen_read_data;
  modport master(output screen_read_en, screen_read_addr, input screen_read_data);
  modport slave(input screen_read_en, screen_read_addr, output screen_read_data);
endinterface

// File: rtl/screen_line_prefetch.sv
// screen_line_prefetch: copies one screen row from screen RAM into a double-buffered line store
module screen_line_prefetch #(
  parameter int unsigned BASE_ADDR   = 'h200,
  parameter int          ADDR_WIDTH  = 11,
  parameter int          COL_BITS    = 5,
  parameter int          ROW_BITS    = 5,
  parameter int          RAM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fetch_req,
  input  logic [ROW_BITS-1:0] fetch_row,
  input  logic                swap,
  screen_line_prefetch_if.master ram,
  input  logic [COL_BITS-1:0] rd_x,
  output logic [7:0]          rd_data,
  output logic                busy,
  output logic                ready,
  output logic                underrun
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t                   state;
  logic [ROW_BITS-1:0]      row;
  logic [COL_BITS-1:0]      col;
  logic                     bank;
  logic [RAM_LATENCY-1:0]   pv;
  logic [COL_BITS-1:0]      pc [RAM_LATENCY];
  logic [7:0]               store [0:2**(COL_BITS+1)-1];
  logic                     last;
  function automatic logic [ADDR_WIDTH-1:0] row_addr(input logic [ROW_BITS-1:0] r, input logic [COL_BITS-1:0] c);
    return ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'({r, c});
  endfunction
  assign last = pv[RAM_LATENCY-1] && (&pc[RAM_LATENCY-1]);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      busy <= 1'b0;
      ready <= 1'b0;
      underrun <= 1'b0;
      bank <= 1'b0;
      row <= '0;
      col <= '0;
      pv <= '0;
      pc <= '{default: '0};
      rd_data <= '0;
      ram.screen_read_en <= 1'b0;
      ram.screen_read_addr <= '0;
    end else begin
      rd_data <= store[{bank, rd_x}];
      for (int i = RAM_LATENCY - 1; i > 0; i--) begin
        pv[i] <= pv[i-1];
        pc[i] <= pc[i-1];
      end
      pv[0] <= state == ISSUE;
      pc[0] <= col;
      // ready is never set while busy, so a swap can only toggle between fetches
      if (swap) begin
        if (ready) begin
          bank <= ~bank;
          ready <= 1'b0;
        end else underrun <= 1'b1;
      end
      case (state)
        IDLE: if (fetch_req) begin
          state <= ISSUE;
          busy <= 1'b1;
          ready <= 1'b0;
          row <= fetch_row;
          col <= '0;
          ram.screen_read_en <= 1'b1;
          ram.screen_read_addr <= row_addr(fetch_row, '0);
        end
        ISSUE: if (&col) begin
          state <= DRAIN;
          ram.screen_read_en <= 1'b0;
        end else begin
          col <= col + 1'b1;
          ram.screen_read_addr <= row_addr(row, col + 1'b1);
        end
        DRAIN: if (last) begin
          state <= IDLE;
          busy <= 1'b0;
          ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge clk)
    if (pv[RAM_LATENCY-1]) store[{~bank, pc[RAM_LATENCY-1]}] <= ram.screen_read_data;
endmodule

// File: tb/tb_screen_line_prefetch.sv
// tb_screen_line_prefetch: randomized checks of the line prefetcher against a row/bank-level model
module tb_screen_line_prefetch;
  logic clk = 0, reset = 0, fetch_req = 0, swap = 0;
  logic [4:0] fetch_row = 0, rd_x = 0;
  logic [7:0] rd_data;
  logic busy, ready, underrun;
  int checks = 0, errors = 0;
  logic [7:0] mem [2048];
  logic [7:0] m_front [32];
  logic [7:0] m_back [32];
  logic m_ready = 0;
  screen_line_prefetch_if bus();
  screen_line_prefetch dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_row(fetch_row), .swap(swap),
    .ram(bus), .rd_x(rd_x), .rd_data(rd_data), .busy(busy), .ready(ready), .underrun(underrun)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.screen_read_en) bus.screen_read_data <= mem[bus.screen_read_addr];
  function automatic logic [10:0] exp_addr(int r, int c);
    return 11'((32'h200 + r * 32 + c) % 2048);
  endfunction
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic fill_linear;
    for (int i = 0; i < 2048; i++) mem[i] = 8'(i);
  endtask
  task automatic fill_random;
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
  endtask
  task automatic load_back(int r);
    for (int c = 0; c < 32; c++) m_back[c] = mem[exp_addr(r, c)];
    m_ready = 1;
  endtask
  task automatic do_fetch(int r);
    int n, t;
    n = 0;
    t = 0;
    fetch_row = 5'(r);
    fetch_req = 1;
    step;
    fetch_req = 0;
    while (!ready && t < 100) begin
      if (bus.screen_read_en) begin
        checks++;
        if (bus.screen_read_addr !== exp_addr(r, n)) begin
          errors++;
          $display("FAIL fetch_addr row %0d col %0d got %h want %h", r, n, bus.screen_read_addr, exp_addr(r, n));
        end
        n++;
      end
      step;
      t++;
    end
    checks++;
    if (n !== 32 || !ready) begin
      errors++;
      $display("FAIL fetch_done row %0d reads %0d ready %b want 32 reads ready 1", r, n, ready);
    end
    load_back(r);
  endtask
  task automatic do_swap;
    swap = 1;
    step;
    swap = 0;
    if (m_ready) begin
      m_front = m_back;
      m_ready = 0;
    end
  endtask
  task automatic check_reads(int n, string tag);
    for (int i = 0; i < n; i++) begin
      rd_x = 5'($urandom_range(31));
      step;
      checks++;
      if (rd_data !== m_front[rd_x]) begin
        errors++;
        $display("FAIL %s rd_x %0d got %h want %h", tag, rd_x, rd_data, m_front[rd_x]);
      end
    end
  endtask
  task automatic test_reset;
    step;
    step;
    checks++;
    if ({busy, ready, underrun, bus.screen_read_en, bus.screen_read_addr, rd_data} !== '0) begin
      errors++;
      $display("FAIL reset busy %b ready %b underrun %b en %b addr %h rd_data %h want all 0",
               busy, ready, underrun, bus.screen_read_en, bus.screen_read_addr, rd_data);
    end
    reset = 1;
    step;
  endtask
  task automatic test_fetch_timing;
    fill_linear;
    fetch_row = 3;
    fetch_req = 1;
    step;
    fetch_req = 0;
    for (int c = 1; c <= 35; c++) begin
      checks++;
      if (bus.screen_read_en !== (c <= 32) || busy !== (c <= 33) || ready !== (c >= 34) ||
          (c <= 32 && bus.screen_read_addr !== 11'(32'h25F + c))) begin
        errors++;
        $display("FAIL timing cycle %0d en %b busy %b ready %b addr %h want en %b busy %b ready %b addr %h",
                 c, bus.screen_read_en, busy, ready, bus.screen_read_addr, c <= 32, c <= 33, c >= 34, 11'(32'h25F + c));
      end
      step;
    end
    load_back(3);
  endtask
  task automatic test_data_swap;
    do_swap;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL swap_ready got %b want 0", ready);
    end
    rd_x = 5;
    step;
    checks++;
    if (rd_data !== 8'h65) begin
      errors++;
      $display("FAIL swap_data got %h want 65", rd_data);
    end
  endtask
  task automatic test_random_rows;
    for (int k = 0; k < 3; k++) begin
      fill_random;
      do_fetch(int'($urandom_range(31)));
      do_swap;
      check_reads(8, "random_row");
    end
  endtask
  task automatic test_underrun;
    int r, t;
    fill_random;
    r = int'($urandom_range(31));
    fetch_row = 5'(r);
    fetch_req = 1;
    step;
    fetch_req = 0;
    repeat (9) step;
    swap = 1;
    step;
    swap = 0;
    checks++;
    if (underrun !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL underrun_set underrun %b busy %b want 1 1", underrun, busy);
    end
    check_reads(4, "underrun_front");
    t = 0;
    while (!ready && t < 100) begin
      step;
      t++;
    end
    checks++;
    if (ready !== 1'b1 || underrun !== 1'b1) begin
      errors++;
      $display("FAIL underrun_finish ready %b underrun %b want 1 1", ready, underrun);
    end
    load_back(r);
    do_swap;
    check_reads(6, "underrun_after_swap");
  endtask
  task automatic test_ignored_request;
    int n, t, extra;
    fill_linear;
    n = 0;
    t = 0;
    extra = 0;
    fetch_row = 3;
    fetch_req = 1;
    step;
    fetch_req = 0;
    while (!ready && t < 100) begin
      fetch_req = (t == 5);
      fetch_row = (t == 5) ? 5'd7 : 5'd3;
      if (bus.screen_read_en) begin
        checks++;
        if (bus.screen_read_addr !== exp_addr(3, n)) begin
          errors++;
          $display("FAIL ignored_addr col %0d got %h want %h", n, bus.screen_read_addr, exp_addr(3, n));
        end
        n++;
      end
      step;
      t++;
    end
    fetch_req = 0;
    repeat (5) begin
      extra += int'(bus.screen_read_en);
      step;
    end
    checks++;
    if (n !== 32 || extra !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignored_count reads %0d extra %0d busy %b want 32 0 0", n, extra, busy);
    end
    load_back(3);
  endtask
  task automatic test_double_buffer;
    do_swap;
    do_fetch(4);
    rd_x = 0;
    step;
    checks++;
    if (rd_data !== 8'h60) begin
      errors++;
      $display("FAIL dbuf_old got %h want 60", rd_data);
    end
    do_swap;
    step;
    checks++;
    if (rd_data !== 8'h80) begin
      errors++;
      $display("FAIL dbuf_new got %h want 80", rd_data);
    end
  endtask
  task automatic test_swap_and_fetch;
    int r1, r2, t;
    logic was_underrun;
    fill_random;
    r1 = int'($urandom_range(31));
    r2 = int'($urandom_range(31));
    do_fetch(r1);
    was_underrun = underrun;
    fetch_row = 5'(r2);
    fetch_req = 1;
    do_swap;
    fetch_req = 0;
    checks++;
    if (busy !== 1'b1 || ready !== 1'b0 || underrun !== was_underrun) begin
      errors++;
      $display("FAIL swap_fetch busy %b ready %b underrun %b want 1 0 %b", busy, ready, underrun, was_underrun);
    end
    check_reads(5, "swap_fetch_front");
    t = 0;
    while (!ready && t < 100) begin
      step;
      t++;
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL swap_fetch_done ready %b want 1", ready);
    end
    load_back(r2);
    do_swap;
    check_reads(6, "swap_fetch_back");
  endtask
  task automatic test_reset_mid;
    fetch_row = 5'($urandom_range(31));
    fetch_req = 1;
    step;
    fetch_req = 0;
    repeat (14) step;
    #2 reset = 0;
    #1;
    checks++;
    if ({busy, ready, bus.screen_read_en, underrun} !== 4'b0) begin
      errors++;
      $display("FAIL reset_mid busy %b ready %b en %b underrun %b want 0 0 0 0",
               busy, ready, bus.screen_read_en, underrun);
    end
    step;
    reset = 1;
    m_ready = 0;
    step;
    fill_linear;
    do_fetch(0);
    do_swap;
    check_reads(4, "reset_mid_row0");
  endtask
  task automatic test_swap_final_write;
    int r;
    fill_random;
    r = int'($urandom_range(31));
    fetch_row = 5'(r);
    fetch_req = 1;
    step;
    fetch_req = 0;
    repeat (32) step;
    checks++;
    if (busy !== 1'b1 || ready !== 1'b0 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL final_cycle busy %b ready %b underrun %b want 1 0 0", busy, ready, underrun);
    end
    swap = 1;
    step;
    swap = 0;
    checks++;
    if (underrun !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL final_swap underrun %b ready %b busy %b want 1 1 0", underrun, ready, busy);
    end
    check_reads(4, "final_swap_front");
    load_back(r);
    do_swap;
    check_reads(6, "final_swap_back");
  endtask
  initial begin
    test_reset;
    test_fetch_timing;
    test_data_swap;
    test_random_rows;
    test_underrun;
    test_ignored_request;
    test_double_buffer;
    test_swap_and_fetch;
    test_reset_mid;
    test_swap_final_write;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
